// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register for the RSA pipelined CPU.
// Captures the decoded instruction and inserts one bubble on a load-use hazard.
module id_ex_pipe #(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 4,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          hold_i,
  input  logic          flush_i,
  input  logic          id_valid_i,
  input  logic          reg_write_i,
  input  logic          mem_to_reg_i,
  input  logic          mem_write_i,
  input  logic          alu_src_i,
  input  logic          flags_write_i,
  input  logic [2:0]    alu_control_i,
  input  logic [DW-1:0] rd1_i,
  input  logic [DW-1:0] rd2_i,
  input  logic [DW-1:0] ext_imm_i,
  input  logic [RW-1:0] ra1_i,
  input  logic [RW-1:0] ra2_i,
  input  logic          use_ra1_i,
  input  logic          use_ra2_i,
  input  logic [RW-1:0] wa_i,
  output logic          ex_valid_o,
  output logic          reg_write_o,
  output logic          mem_to_reg_o,
  output logic          mem_write_o,
  output logic          alu_src_o,
  output logic          flags_write_o,
  output logic [2:0]    alu_control_o,
  output logic [DW-1:0] rd1_o,
  output logic [DW-1:0] rd2_o,
  output logic [DW-1:0] ext_imm_o,
  output logic [RW-1:0] wa_o,
  output logic          stall_o,
  output logic [CW-1:0] bubble_cnt_o
);

  typedef struct packed {
    logic          valid;
    logic          reg_write;
    logic          mem_to_reg;
    logic          mem_write;
    logic          alu_src;
    logic          flags_write;
    logic [2:0]    alu_control;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic [DW-1:0] ext_imm;
    logic [RW-1:0] wa;
  } ex_t;

  ex_t           ex_q, ex_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lu;

  always_comb begin
    lu = id_valid_i & ex_q.valid & ex_q.mem_to_reg & ex_q.reg_write &
         ((use_ra1_i & (ra1_i == ex_q.wa)) | (use_ra2_i & (ra2_i == ex_q.wa)));
    stall_o = lu & ~flush_i;

    ex_d  = ex_q;
    cnt_d = cnt_q;
    // An all-zero entry is the bubble: no valid, no write enables.
    if (flush_i) begin
      ex_d = '0;
    end else if (hold_i) begin
      ex_d = ex_q;
    end else if (lu) begin
      ex_d = '0;
      if (cnt_q != '1) cnt_d = cnt_q + CW'(1);
    end else begin
      ex_d.valid       = id_valid_i;
      ex_d.reg_write   = reg_write_i;
      ex_d.mem_to_reg  = mem_to_reg_i;
      ex_d.mem_write   = mem_write_i;
      ex_d.alu_src     = alu_src_i;
      ex_d.flags_write = flags_write_i;
      ex_d.alu_control = alu_control_i;
      ex_d.rd1         = rd1_i;
      ex_d.rd2         = rd2_i;
      ex_d.ext_imm     = ext_imm_i;
      ex_d.wa          = wa_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign ex_valid_o    = ex_q.valid;
  assign reg_write_o   = ex_q.reg_write;
  assign mem_to_reg_o  = ex_q.mem_to_reg;
  assign mem_write_o   = ex_q.mem_write;
  assign alu_src_o     = ex_q.alu_src;
  assign flags_write_o = ex_q.flags_write;
  assign alu_control_o = ex_q.alu_control;
  assign rd1_o         = ex_q.rd1;
  assign rd2_o         = ex_q.rd2;
  assign ext_imm_o     = ex_q.ext_imm;
  assign wa_o          = ex_q.wa;
  assign bubble_cnt_o  = cnt_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Directed bench for id_ex_pipe: reset, pass-through, load-use, flush/hold priority, saturation.
module tb_id_ex_pipe;

  logic        clk, rst_n, hold_i, flush_i, id_valid_i;
  logic        reg_write_i, mem_to_reg_i, mem_write_i, alu_src_i, flags_write_i;
  logic [2:0]  alu_control_i;
  logic [31:0] rd1_i, rd2_i, ext_imm_i;
  logic [3:0]  ra1_i, ra2_i, wa_i;
  logic        use_ra1_i, use_ra2_i;

  logic        ex_valid_o, reg_write_o, mem_to_reg_o, mem_write_o, alu_src_o, flags_write_o;
  logic [2:0]  alu_control_o;
  logic [31:0] rd1_o, rd2_o, ext_imm_o;
  logic [3:0]  wa_o;
  logic        stall_o;
  logic [15:0] bubble_cnt_o;

  logic        s_ex_valid_o, s_reg_write_o, s_mem_to_reg_o, s_mem_write_o, s_alu_src_o, s_flags_write_o;
  logic [2:0]  s_alu_control_o;
  logic [31:0] s_rd1_o, s_rd2_o, s_ext_imm_o;
  logic [3:0]  s_wa_o;
  logic        s_stall_o;
  logic [1:0]  s_bubble_cnt_o;

  logic [108:0] ex_all, snap;
  int checks = 0;
  int failures = 0;
  logic [15:0] exp_cnt;

  assign ex_all = {ex_valid_o, reg_write_o, mem_to_reg_o, mem_write_o, alu_src_o, flags_write_o,
                   alu_control_o, rd1_o, rd2_o, ext_imm_o, wa_o};

  id_ex_pipe #(.DW(32), .RW(4), .CW(16)) dut (
    .clk(clk), .rst_n(rst_n), .hold_i(hold_i), .flush_i(flush_i), .id_valid_i(id_valid_i),
    .reg_write_i(reg_write_i), .mem_to_reg_i(mem_to_reg_i), .mem_write_i(mem_write_i),
    .alu_src_i(alu_src_i), .flags_write_i(flags_write_i), .alu_control_i(alu_control_i),
    .rd1_i(rd1_i), .rd2_i(rd2_i), .ext_imm_i(ext_imm_i), .ra1_i(ra1_i), .ra2_i(ra2_i),
    .use_ra1_i(use_ra1_i), .use_ra2_i(use_ra2_i), .wa_i(wa_i),
    .ex_valid_o(ex_valid_o), .reg_write_o(reg_write_o), .mem_to_reg_o(mem_to_reg_o),
    .mem_write_o(mem_write_o), .alu_src_o(alu_src_o), .flags_write_o(flags_write_o),
    .alu_control_o(alu_control_o), .rd1_o(rd1_o), .rd2_o(rd2_o), .ext_imm_o(ext_imm_o),
    .wa_o(wa_o), .stall_o(stall_o), .bubble_cnt_o(bubble_cnt_o)
  );

  // Narrow counter copy so saturation is reachable in a few hazards.
  id_ex_pipe #(.DW(32), .RW(4), .CW(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .hold_i(hold_i), .flush_i(flush_i), .id_valid_i(id_valid_i),
    .reg_write_i(reg_write_i), .mem_to_reg_i(mem_to_reg_i), .mem_write_i(mem_write_i),
    .alu_src_i(alu_src_i), .flags_write_i(flags_write_i), .alu_control_i(alu_control_i),
    .rd1_i(rd1_i), .rd2_i(rd2_i), .ext_imm_i(ext_imm_i), .ra1_i(ra1_i), .ra2_i(ra2_i),
    .use_ra1_i(use_ra1_i), .use_ra2_i(use_ra2_i), .wa_i(wa_i),
    .ex_valid_o(s_ex_valid_o), .reg_write_o(s_reg_write_o), .mem_to_reg_o(s_mem_to_reg_o),
    .mem_write_o(s_mem_write_o), .alu_src_o(s_alu_src_o), .flags_write_o(s_flags_write_o),
    .alu_control_o(s_alu_control_o), .rd1_o(s_rd1_o), .rd2_o(s_rd2_o), .ext_imm_o(s_ext_imm_o),
    .wa_o(s_wa_o), .stall_o(s_stall_o), .bubble_cnt_o(s_bubble_cnt_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic clear_inputs();
    hold_i = 0; flush_i = 0; id_valid_i = 0;
    reg_write_i = 0; mem_to_reg_i = 0; mem_write_i = 0; alu_src_i = 0; flags_write_i = 0;
    alu_control_i = '0; rd1_i = '0; rd2_i = '0; ext_imm_i = '0;
    ra1_i = '0; ra2_i = '0; use_ra1_i = 0; use_ra2_i = 0; wa_i = '0;
  endtask

  // Put an LDR writing register r into EX (one edge).
  task automatic put_ldr(input logic [3:0] r);
    @(negedge clk);
    clear_inputs();
    id_valid_i = 1; reg_write_i = 1; mem_to_reg_i = 1; wa_i = r; ext_imm_i = 32'h10;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    clear_inputs();
    id_valid_i = 1; reg_write_i = 1; mem_to_reg_i = 1; mem_write_i = 1; alu_src_i = 1;
    flags_write_i = 1; alu_control_i = '1; rd1_i = '1; rd2_i = '1; ext_imm_i = '1;
    ra1_i = '1; ra2_i = '1; use_ra1_i = 1; use_ra2_i = 1; wa_i = '1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ex_all !== '0) begin failures++; $display("FAIL reset_ex got=%h exp=0", ex_all); end
    checks++; if (bubble_cnt_o !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", bubble_cnt_o); end
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall_o); end
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    checks++; if (ex_all !== '1) begin failures++; $display("FAIL reset_first_capture got=%h exp=all ones", ex_all); end
    checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL reset_capture_stall got=%b exp=1", stall_o); end
    #2 rst_n = 0;
    #1;
    checks++; if (ex_all !== '0 || bubble_cnt_o !== 16'd0) begin failures++; $display("FAIL async_reset got=%h cnt=%0d exp=0", ex_all, bubble_cnt_o); end
    clear_inputs();
    @(negedge clk); rst_n = 1;
    exp_cnt = 0;
  endtask

  task automatic test_add();
    @(negedge clk);
    clear_inputs();
    id_valid_i = 1; reg_write_i = 1; alu_control_i = 3'b000; rd1_i = 5; rd2_i = 7; wa_i = 3;
    #1;
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL add_stall got=%b exp=0", stall_o); end
    @(posedge clk); #1;
    checks++;
    if (ex_all !== {1'b1, 1'b1, 4'b0000, 3'b000, 32'd5, 32'd7, 32'd0, 4'd3}) begin
      failures++; $display("FAIL add_pass got=%h exp=%h", ex_all, {1'b1, 1'b1, 4'b0000, 3'b000, 32'd5, 32'd7, 32'd0, 4'd3});
    end
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL add_stall_after got=%b exp=0", stall_o); end
  endtask

  task automatic test_load_use();
    put_ldr(4'd2);
    @(negedge clk);
    clear_inputs();
    id_valid_i = 1; reg_write_i = 1; ra1_i = 2; use_ra1_i = 1; wa_i = 4; rd1_i = 11; rd2_i = 22;
    #1;
    checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL lu_stall got=%b exp=1", stall_o); end
    @(posedge clk); #1;
    exp_cnt = exp_cnt + 1;
    checks++; if (ex_all !== '0) begin failures++; $display("FAIL lu_bubble got=%h exp=0", ex_all); end
    checks++; if (bubble_cnt_o !== exp_cnt) begin failures++; $display("FAIL lu_cnt got=%0d exp=%0d", bubble_cnt_o, exp_cnt); end
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL lu_stall_release got=%b exp=0", stall_o); end
    @(posedge clk); #1;
    checks++;
    if ({ex_valid_o, reg_write_o, wa_o, rd1_o, rd2_o} !== {1'b1, 1'b1, 4'd4, 32'd11, 32'd22}) begin
      failures++; $display("FAIL lu_advance got=%b %b %0d %0d %0d exp=1 1 4 11 22", ex_valid_o, reg_write_o, wa_o, rd1_o, rd2_o);
    end
    checks++; if (bubble_cnt_o !== exp_cnt) begin failures++; $display("FAIL lu_cnt_hold got=%0d exp=%0d", bubble_cnt_o, exp_cnt); end
  endtask

  task automatic test_no_false_hazard();
    @(negedge clk);
    clear_inputs();
    id_valid_i = 1; mem_to_reg_i = 1; mem_write_i = 1; wa_i = 2;
    @(posedge clk); #1;
    @(negedge clk);
    clear_inputs();
    id_valid_i = 1; reg_write_i = 1; ra1_i = 2; use_ra1_i = 1; wa_i = 5;
    #1;
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL str_no_stall got=%b exp=0", stall_o); end
    @(posedge clk); #1;
    checks++; if ({ex_valid_o, wa_o, bubble_cnt_o} !== {1'b1, 4'd5, exp_cnt}) begin
      failures++; $display("FAIL str_advance got=%b %0d %0d exp=1 5 %0d", ex_valid_o, wa_o, bubble_cnt_o, exp_cnt);
    end
    put_ldr(4'd2);
    @(negedge clk);
    clear_inputs();
    id_valid_i = 1; reg_write_i = 1; ra1_i = 2; ra2_i = 2;
    #1;
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL unused_ra_no_stall got=%b exp=0", stall_o); end
    use_ra2_i = 1;
    #1;
    checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL ra2_stall got=%b exp=1", stall_o); end
    id_valid_i = 0;
    #1;
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL invalid_id_no_stall got=%b exp=0", stall_o); end
    clear_inputs();
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    put_ldr(4'd5);
    @(negedge clk);
    clear_inputs();
    id_valid_i = 1; reg_write_i = 1; ra2_i = 5; use_ra2_i = 1; wa_i = 6;
    flush_i = 1; hold_i = 1;
    #1;
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL flush_stall got=%b exp=0", stall_o); end
    @(posedge clk); #1;
    checks++; if (ex_all !== '0) begin failures++; $display("FAIL flush_bubble got=%h exp=0", ex_all); end
    checks++; if (bubble_cnt_o !== exp_cnt) begin failures++; $display("FAIL flush_cnt got=%0d exp=%0d", bubble_cnt_o, exp_cnt); end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_hold();
    @(negedge clk);
    clear_inputs();
    id_valid_i = 1; reg_write_i = 1; alu_src_i = 1; flags_write_i = 1; alu_control_i = 3'b101;
    rd1_i = 32'hAAAA; rd2_i = 32'hBBBB; ext_imm_i = 32'hCCCC; wa_i = 7;
    @(posedge clk); #1;
    snap = {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'b101, 32'hAAAA, 32'hBBBB, 32'hCCCC, 4'd7};
    checks++; if (ex_all !== snap) begin failures++; $display("FAIL hold_load got=%h exp=%h", ex_all, snap); end
    @(negedge clk);
    hold_i = 1; id_valid_i = 0; rd1_i = 32'h1; rd2_i = 32'h2; wa_i = 9; alu_control_i = 3'b010;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if (ex_all !== snap) begin failures++; $display("FAIL hold_cycle%0d got=%h exp=%h", i, ex_all, snap); end
    end
    // Hold with a pending load-use: no bubble, no count, stall still visible.
    @(negedge clk); hold_i = 0;
    put_ldr(4'd6);
    snap = ex_all;
    @(negedge clk);
    clear_inputs();
    hold_i = 1; id_valid_i = 1; reg_write_i = 1; ra1_i = 6; use_ra1_i = 1; wa_i = 8;
    #1;
    checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL hold_lu_stall got=%b exp=1", stall_o); end
    @(posedge clk); #1;
    checks++; if ({ex_valid_o, mem_to_reg_o, wa_o} !== {1'b1, 1'b1, 4'd6} || bubble_cnt_o !== exp_cnt) begin
      failures++; $display("FAIL hold_lu_frozen got=%b %b %0d cnt=%0d exp=1 1 6 cnt=%0d", ex_valid_o, mem_to_reg_o, wa_o, bubble_cnt_o, exp_cnt);
    end
    @(negedge clk); hold_i = 0;
    @(posedge clk); #1;
    exp_cnt = exp_cnt + 1;
    checks++; if (ex_all !== '0 || bubble_cnt_o !== exp_cnt) begin
      failures++; $display("FAIL hold_release_bubble got=%h cnt=%0d exp=0 cnt=%0d", ex_all, bubble_cnt_o, exp_cnt);
    end
    @(posedge clk); #1;
    checks++; if ({ex_valid_o, wa_o} !== {1'b1, 4'd8}) begin failures++; $display("FAIL hold_release_advance got=%b %0d exp=1 8", ex_valid_o, wa_o); end
  endtask

  task automatic test_back_to_back();
    put_ldr(4'd1);
    @(negedge clk);
    clear_inputs();
    id_valid_i = 1; reg_write_i = 1; mem_to_reg_i = 1; ra1_i = 1; use_ra1_i = 1; wa_i = 2;
    #1;
    checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL b2b_stall1 got=%b exp=1", stall_o); end
    @(posedge clk); #1;
    exp_cnt = exp_cnt + 1;
    checks++; if (ex_valid_o !== 1'b0 || bubble_cnt_o !== exp_cnt) begin failures++; $display("FAIL b2b_bubble1 got=%b cnt=%0d exp=0 cnt=%0d", ex_valid_o, bubble_cnt_o, exp_cnt); end
    @(posedge clk); #1;
    checks++; if ({ex_valid_o, mem_to_reg_o, wa_o} !== {1'b1, 1'b1, 4'd2}) begin failures++; $display("FAIL b2b_ldr2 got=%b %b %0d exp=1 1 2", ex_valid_o, mem_to_reg_o, wa_o); end
    @(negedge clk);
    clear_inputs();
    id_valid_i = 1; reg_write_i = 1; ra2_i = 2; use_ra2_i = 1; wa_i = 3;
    #1;
    checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL b2b_stall2 got=%b exp=1", stall_o); end
    @(posedge clk); #1;
    exp_cnt = exp_cnt + 1;
    checks++; if (ex_valid_o !== 1'b0 || bubble_cnt_o !== exp_cnt) begin failures++; $display("FAIL b2b_bubble2 got=%b cnt=%0d exp=0 cnt=%0d", ex_valid_o, bubble_cnt_o, exp_cnt); end
    @(posedge clk); #1;
    checks++; if ({ex_valid_o, wa_o} !== {1'b1, 4'd3}) begin failures++; $display("FAIL b2b_add got=%b %0d exp=1 3", ex_valid_o, wa_o); end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_s;
    @(negedge clk);
    clear_inputs();
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    exp_cnt = 0;
    exp_s = 0;
    for (int i = 0; i < 4; i++) begin
      put_ldr(4'd2);
      @(negedge clk);
      clear_inputs();
      id_valid_i = 1; reg_write_i = 1; ra1_i = 2; use_ra1_i = 1; wa_i = 4;
      @(posedge clk); #1;
      exp_cnt = exp_cnt + 1;
      if (exp_s != 2'b11) exp_s = exp_s + 1;
      checks++; if (bubble_cnt_o !== exp_cnt) begin failures++; $display("FAIL sat_main_cnt%0d got=%0d exp=%0d", i, bubble_cnt_o, exp_cnt); end
      checks++; if (s_bubble_cnt_o !== exp_s) begin failures++; $display("FAIL sat_cnt%0d got=%0d exp=%0d", i, s_bubble_cnt_o, exp_s); end
    end
    checks++; if (s_ex_valid_o !== 1'b0) begin failures++; $display("FAIL sat_bubble got=%b exp=0", s_ex_valid_o); end
  endtask

  initial begin
    clear_inputs();
    rst_n = 0;
    exp_cnt = 0;
    test_reset();
    test_add();
    test_load_use();
    test_no_false_hazard();
    test_flush();
    test_hold();
    test_back_to_back();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
